// File: rtl/rojobot_pkg.sv
// Shared types for the train hit detector: FSM state encoding,
// score ceiling and a saturating score increment helper.
package rojobot_pkg;

   typedef enum logic [2:0] {
      ARMED,
      FIRE,
      WAIT_BURST,
      BURSTING,
      RESPAWN,
      COOLDOWN
   } hit_state_t;

   localparam logic [7:0] HIT_CNT_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == HIT_CNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/frame_overlap_acc.sv
// Per-frame overlap accumulator: detects the frame boundary, counts
// visible train/shot overlap pixels (saturating) and gives the verdict.
// Ports: clk, reset (sync, active-low), pixel_row/pixel_column scan
// position, video_on/train_flag/shot_flag pixel qualifiers;
// frame_start strobe and hit_frame verdict (valid in frame_start cycle).
module frame_overlap_acc
   import rojobot_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MIN_OVERLAP = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] pixel_row,
   input  logic [11:0] pixel_column,
   input  logic        video_on,
   input  logic        train_flag,
   input  logic        shot_flag,
   output logic        frame_start,
   output logic        hit_frame
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_OVERLAP);

   logic [11:0]      prev_row;
   logic [11:0]      prev_col;
   logic [CNT_W-1:0] overlap_cnt;
   logic             overlap;

   assign overlap = video_on & train_flag & shot_flag;

   assign frame_start = (pixel_row == '0) && (pixel_column == '0) &&
                        ((prev_row != '0) || (prev_col != '0));

   // Verdict on the frame that closes now; the pixel at 0,0 already
   // belongs to the next frame and is not part of this count.
   assign hit_frame = frame_start && (overlap_cnt >= MIN_CNT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_row    <= '0;
         prev_col    <= '0;
         overlap_cnt <= '0;
      end else begin
         prev_row <= pixel_row;
         prev_col <= pixel_column;
         if (frame_start)
            overlap_cnt <= overlap ? CNT_W'(1) : '0;
         else if (overlap && overlap_cnt != CNT_MAX)
            overlap_cnt <= overlap_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/train_hit_detector.sv
// Train hit request generator: fires a one-cycle train_hit/shot_clear
// when a frame had enough overlap, then follows the sprite block's
// burst/train_reset handshake and a frame cooldown before re-arming.
// Ports: clk, reset (sync, active-low), scan position and pixel flags,
// burst/train_reset from the sprite block; train_hit, shot_clear,
// hit_count (saturating score), ack_err (sticky), armed.
module train_hit_detector
   import rojobot_pkg::*;
#(
   parameter int MIN_OVERLAP     = 4,
   parameter int COOLDOWN_FRAMES = 30,
   parameter int ACK_TIMEOUT     = 16,
   parameter int CNT_W           = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] pixel_row,
   input  logic [11:0] pixel_column,
   input  logic        video_on,
   input  logic        train_flag,
   input  logic        shot_flag,
   input  logic        burst,
   input  logic        train_reset,
   output logic        train_hit,
   output logic        shot_clear,
   output logic [7:0]  hit_count,
   output logic        ack_err,
   output logic        armed
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_FRAMES - 1);

   hit_state_t      state;
   logic [TO_W-1:0] to_cnt;
   logic [CD_W-1:0] cd_cnt;
   logic            frame_start;
   logic            hit_frame;

   frame_overlap_acc #(
      .CNT_W       (CNT_W),
      .MIN_OVERLAP (MIN_OVERLAP)
   ) u_acc (
      .clk          (clk),
      .reset        (reset),
      .pixel_row    (pixel_row),
      .pixel_column (pixel_column),
      .video_on     (video_on),
      .train_flag   (train_flag),
      .shot_flag    (shot_flag),
      .frame_start  (frame_start),
      .hit_frame    (hit_frame)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ARMED;
         armed      <= 1'b1;
         train_hit  <= 1'b0;
         shot_clear <= 1'b0;
         hit_count  <= '0;
         ack_err    <= 1'b0;
         to_cnt     <= '0;
         cd_cnt     <= '0;
      end else begin
         train_hit  <= 1'b0;
         shot_clear <= 1'b0;
         unique case (state)
            ARMED: begin
               // Pulses are registered on entry so they are
               // visible exactly during the FIRE cycle.
               if (hit_frame) begin
                  state      <= FIRE;
                  armed      <= 1'b0;
                  train_hit  <= 1'b1;
                  shot_clear <= 1'b1;
               end
            end
            FIRE: begin
               hit_count <= sat_inc8(hit_count);
               to_cnt    <= '0;
               state     <= WAIT_BURST;
            end
            WAIT_BURST: begin
               if (burst) begin
                  state <= BURSTING;
               end else if (to_cnt == TO_LAST) begin
                  ack_err <= 1'b1;
                  armed   <= 1'b1;
                  state   <= ARMED;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            BURSTING: begin
               if (train_reset)
                  state <= RESPAWN;
            end
            RESPAWN: begin
               if (!train_reset) begin
                  cd_cnt <= '0;
                  state  <= COOLDOWN;
               end
            end
            COOLDOWN: begin
               // A verdict arriving on the re-arming boundary is
               // dropped: it belongs to a frame seen while cooling.
               if (frame_start) begin
                  if (cd_cnt == CD_LAST) begin
                     armed <= 1'b1;
                     state <= ARMED;
                  end else begin
                     cd_cnt <= cd_cnt + CD_W'(1);
                  end
               end
            end
            default: begin
               armed <= 1'b1;
               state <= ARMED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_train_hit_detector.sv
// Self-checking bench for train_hit_detector: directed scenarios plus
// randomized frames, compared every cycle against a behavioural model.
module tb_train_hit_detector;
   import rojobot_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] pixel_row;
   logic [11:0] pixel_column;
   logic        video_on;
   logic        train_flag;
   logic        shot_flag;
   logic        burst;
   logic        train_reset;
   logic        train_hit;
   logic        shot_clear;
   logic [7:0]  hit_count;
   logic        ack_err;
   logic        armed;

   always #5 clk = ~clk;

   train_hit_detector dut (
      .clk          (clk),
      .reset        (reset),
      .pixel_row    (pixel_row),
      .pixel_column (pixel_column),
      .video_on     (video_on),
      .train_flag   (train_flag),
      .shot_flag    (shot_flag),
      .burst        (burst),
      .train_reset  (train_reset),
      .train_hit    (train_hit),
      .shot_clear   (shot_clear),
      .hit_count    (hit_count),
      .ack_err      (ack_err),
      .armed        (armed)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: frame overlap as a plain integer, the handshake
   // as "what are we waiting for" flags and countdowns.
   int m_cnt = 0;
   bit m_prev_zero = 1'b1;
   bit m_fire = 1'b0;
   bit m_armed = 1'b0;
   int m_ack_left = 0;
   bit m_need_hi = 1'b0;
   bit m_need_lo = 1'b0;
   int m_cool = 0;
   int m_hits = 0;
   bit m_err = 1'b0;

   always @(posedge clk) begin
      bit at0, fs, ov, verdict;
      at0 = (pixel_row == 0) && (pixel_column == 0);
      fs = at0 && !m_prev_zero;
      m_prev_zero = at0;
      ov = video_on && train_flag && shot_flag;
      verdict = fs && (m_cnt >= 4);
      if (fs) m_cnt = ov;
      else if (ov && m_cnt < 65535) m_cnt++;
      if (!reset) begin
         m_cnt = 0; m_prev_zero = 1'b1; m_fire = 1'b0; m_armed = 1'b1;
         m_ack_left = 0; m_need_hi = 1'b0; m_need_lo = 1'b0;
         m_cool = 0; m_hits = 0; m_err = 1'b0;
      end else if (m_fire) begin
         m_fire = 1'b0;
         m_hits = (m_hits < 255) ? m_hits + 1 : 255;
         m_ack_left = 16;
      end else if (m_ack_left > 0) begin
         if (burst) begin
            m_ack_left = 0; m_need_hi = 1'b1;
         end else begin
            m_ack_left--;
            if (m_ack_left == 0) begin m_err = 1'b1; m_armed = 1'b1; end
         end
      end else if (m_need_hi) begin
         if (train_reset) begin m_need_hi = 1'b0; m_need_lo = 1'b1; end
      end else if (m_need_lo) begin
         if (!train_reset) begin m_need_lo = 1'b0; m_cool = 30; end
      end else if (m_cool > 0) begin
         if (fs) begin
            m_cool--;
            if (m_cool == 0) m_armed = 1'b1;
         end
      end else if (m_armed && verdict) begin
         m_armed = 1'b0; m_fire = 1'b1;
      end
   end

   // Stimulus and observation state
   int r = 0, c = 0;
   bit last_zero = 1'b1;
   int frames_since = 0;
   int last_fs_at = -10;
   int n_hit = 0, n_shot = 0, lat_bad = 0;
   int hit_cyc = 0, err_cyc = 0, hit_fs_idx = -1;
   bit prev_err = 1'b0;
   bit auto_ack = 1'b0;
   bit chk_on = 1'b0;
   int a_dly = 0, a_wait = 0, a_len = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic px(input bit ov);
      bit t, s;
      @(negedge clk);
      if (chk_on) begin
         chk("train_hit", train_hit, m_fire);
         chk("shot_clear", shot_clear, m_fire);
         chk("armed", armed, m_armed);
         chk("hit_count", hit_count, m_hits);
         chk("ack_err", ack_err, m_err);
      end
      if (train_hit) begin
         n_hit++;
         hit_cyc = cyc;
         hit_fs_idx = frames_since;
         if (cyc != last_fs_at) lat_bad++;
      end
      if (shot_clear) n_shot++;
      if (ack_err && !prev_err) err_cyc = cyc;
      prev_err = ack_err;
      if (auto_ack) begin
         if (train_hit) begin
            a_dly = $urandom_range(1, 20); a_wait = 0; a_len = 0;
         end else if (a_dly > 0) begin
            a_dly--;
            if (a_dly == 0) begin
               burst = 1'b1; a_wait = $urandom_range(1, 12);
            end
         end else if (a_wait > 0) begin
            a_wait--;
            if ($urandom_range(0, 3) == 0) burst = 1'b0;
            if (a_wait == 0) begin
               train_reset = 1'b1; a_len = $urandom_range(1, 6);
            end
         end else if (a_len > 0) begin
            a_len--;
            if (a_len == 0) begin train_reset = 1'b0; burst = 1'b0; end
         end
      end
      pixel_row = 12'(r);
      pixel_column = 12'(c);
      video_on = (r < 3);
      if (r == 0 && c == 0 && !last_zero) begin
         frames_since++;
         last_fs_at = cyc + 1;
      end
      last_zero = (r == 0 && c == 0);
      if (video_on && ov) begin
         t = 1'b1; s = 1'b1;
      end else begin
         t = 1'($urandom); s = 1'($urandom);
         if (video_on && t && s) s = 1'b0;
      end
      train_flag = t;
      shot_flag = s;
      c++;
      if (c == 8) begin c = 0; r = (r + 1) % 4; end
   endtask

   // Runs to the end of the current frame with n visible overlaps.
   task automatic frame(input int n);
      int start, idx;
      start = (n >= 24) ? 0 : $urandom_range(0, 24 - n);
      do begin
         idx = r * 8 + c;
         px(r < 3 && idx >= start && idx < start + n);
      end while (!(r == 0 && c == 0));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      r = 0; c = 0;
      repeat (3) px(1'b0);
      r = 0; c = 0;
      last_zero = 1'b1;
      reset = 1'b1;
   endtask

   function automatic int pick();
      case ($urandom_range(0, 5))
         0: return 0;
         1: return 2;
         2: return 3;
         3: return 4;
         4: return 5;
         default: return 12;
      endcase
   endfunction

   initial begin
      int n0;
      reset = 1'b0;
      pixel_row = '0; pixel_column = '0;
      video_on = 1'b0; train_flag = 1'b0; shot_flag = 1'b0;
      burst = 1'b0; train_reset = 1'b0;
      do_reset();
      chk_on = 1'b1;
      chk("rst_armed", armed, 1);
      chk("rst_hit_count", hit_count, 0);
      chk("rst_train_hit", train_hit, 0);
      chk("rst_ack_err", ack_err, 0);

      // Three overlaps: below threshold
      frame(3);
      frame(0);
      chk("three_px_no_hit", n_hit, 0);
      chk("three_px_count", hit_count, 0);
      chk("three_px_armed", armed, 1);

      // Five overlaps: hit, acknowledged by burst
      frame(5);
      repeat (4) px(1'b0);
      burst = 1'b1;
      frame(0);
      chk("five_px_hits", n_hit, 1);
      chk("five_px_shot", n_shot, 1);
      chk("hit_latency_bad", lat_bad, 0);
      chk("five_px_count", hit_count, 1);
      chk("five_px_armed", armed, 0);
      chk("state_bursting", 32'(dut.state), 32'(BURSTING));
      chk("model_hits_1", m_hits, 1);

      // Respawn, then cooldown over 30 frames of heavy overlap
      train_reset = 1'b1;
      repeat (16) px(1'b0);
      train_reset = 1'b0;
      burst = 1'b0;
      frames_since = 0;
      frame(0);
      n0 = n_hit;
      for (int f = 0; f < 40 && n_hit == n0; f++) frame(10);
      chk("cooldown_first_hit_frame", hit_fs_idx, 31);
      chk("cooldown_count", hit_count, 2);

      // No burst: acknowledge timeout
      chk("ack_err_latency", err_cyc - hit_cyc, 17);
      chk("ack_err_set", ack_err, 1);
      chk("ack_err_armed", armed, 1);
      chk("ack_err_no_refire", n_hit, 2);

      // Saturate the score through repeated timed-out hits
      for (int f = 0; f < 300 && hit_count != 8'hFF; f++) frame(10);
      chk("sat_reached", hit_count, 255);
      n0 = n_hit;
      frame(0);
      frame(0);
      chk("sat_hold", hit_count, 255);
      chk("sat_still_fires", n_hit - n0, 1);
      chk("model_sat", m_hits, 255);

      // Randomized frames with a randomized sprite block
      auto_ack = 1'b1;
      repeat (80) frame(pick());
      auto_ack = 1'b0;

      // Drive to BURSTING, then reset mid-operation
      burst = 1'b0;
      train_reset = 1'b1;
      px(1'b0); px(1'b0);
      train_reset = 1'b0;
      for (int f = 0; f < 40 && armed !== 1'b1; f++) frame(0);
      chk("pre_rst_armed", armed, 1);
      frame(10);
      burst = 1'b1;
      for (int k = 0; k < 40 && dut.state != BURSTING; k++) px(1'b0);
      chk("pre_rst_bursting", 32'(dut.state), 32'(BURSTING));
      repeat (3) px(1'b1);
      px(1'b0);
      chk("pre_rst_overlap", 32'(dut.u_acc.overlap_cnt), 3);
      reset = 1'b0;
      px(1'b0);
      chk("mid_rst_armed", armed, 1);
      chk("mid_rst_hit_count", hit_count, 0);
      chk("mid_rst_train_hit", train_hit, 0);
      chk("mid_rst_ack_err", ack_err, 0);
      chk("mid_rst_overlap", 32'(dut.u_acc.overlap_cnt), 0);
      burst = 1'b0;
      do_reset();

      auto_ack = 1'b1;
      repeat (120) frame(pick());
      auto_ack = 1'b0;
      frame(0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/train_hit_detector.md
Name: train_hit_detector

Overview:
- Generates the `train_hit` request consumed by the train sprite/explosion block.
- Watches the pixel-rate sprite flags of the train and the projectile, and counts overlapping pixels per video frame.
- At each frame boundary, issues a one-cycle hit pulse when enough pixels overlapped.
- Tracks the sprite block's `burst`/`train_reset` acknowledgement through cooldown before re-arming, and keeps a saturating hit score.

Parameters:
- MIN_OVERLAP, 4: overlapping pixels in one frame required to declare a hit.
- COOLDOWN_FRAMES, 30: whole frames after `train_reset` falls before re-arming.
- ACK_TIMEOUT, 16: clocks allowed between the `train_hit` pulse and `burst` rising.
- CNT_W, 16: width of the per-frame overlap counter.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-low reset
- pixel_row  in  12  current scan row
- pixel_column  in  12  current scan column
- video_on  in  1  visible-region qualifier
- train_flag  in  1  train sprite opaque at current pixel; same registered alignment as shot_flag
- shot_flag  in  1  projectile sprite opaque at current pixel
- burst  in  1  explosion active, from the sprite block
- train_reset  in  1  post-explosion respawn pulse/level, from the sprite block
- train_hit  out  1  one-cycle hit request
- shot_clear  out  1  one-cycle pulse, same cycle as train_hit; retires the projectile
- hit_count  out  8  saturating score
- ack_err  out  1  sticky: burst never arrived within ACK_TIMEOUT
- armed  out  1  high only in ARMED

Behaviour:
- Reset (reset==0 at posedge clk): all registers clear; state=ARMED, armed=1, all other outputs 0, overlap_cnt=0.
- Frame start (frame_start): the cycle in which {pixel_row,pixel_column} == 0,0 and the previous cycle's value was not 0,0. It is a one-cycle internal strobe.
- Overlap accumulation:
  - When video_on & train_flag & shot_flag, overlap_cnt increments.
  - overlap_cnt saturates at 2^CNT_W-1.
  - On frame_start, the frame result is latched: hit_frame = (overlap_cnt >= MIN_OVERLAP). overlap_cnt then clears.
  - If frame_start coincides with an overlapping pixel, the count restarts at 1 for the new frame.
- Accumulation runs in every state. hit_frame is acted on only in ARMED.
- FSM states and transitions:
  - ARMED: hit_frame on frame_start → FIRE.
  - FIRE, exactly one cycle:
    - train_hit=1 and shot_clear=1.
    - hit_count increments and holds at 255.
    - Next state → WAIT_BURST; timeout counter clears.
  - WAIT_BURST:
    - burst==1 → BURSTING.
    - Otherwise the counter increments. When it reaches ACK_TIMEOUT: ack_err=1, → ARMED with no re-fire.
    - burst already high on entry counts as acknowledge in the first WAIT_BURST cycle.
  - BURSTING: wait for train_reset==1 → RESPAWN.
    - burst falling without train_reset is ignored; the FSM keeps waiting.
  - RESPAWN: wait for train_reset==0 → COOLDOWN; frame counter clears.
  - COOLDOWN:
    - Frame counter increments on each frame_start.
    - At COOLDOWN_FRAMES → ARMED.
    - A hit_frame latched on that same frame_start is discarded, not fired.
- Latency: train_hit asserts exactly one clock after the frame_start that closes a qualifying frame.
- Only one train_hit per FIRE entry. No second pulse is possible until ARMED is re-entered.
- ack_err clears only on reset.
- Reset mid-operation returns to ARMED immediately. hit_count and ack_err clear.

Decomposition:
- Shared package rojobot_pkg holds:
  - state enum hit_state_t {ARMED, FIRE, WAIT_BURST, BURSTING, RESPAWN, COOLDOWN};
  - HIT_CNT_MAX = 8'hFF.
- One sub-module, frame_overlap_acc, owns:
  - frame_start detection;
  - the saturating overlap counter;
  - the hit_frame latch.
- The parent holds the FSM, timeout counter, cooldown counter and score.

Test Plan:
- Reset, then 3 overlapping pixels in frame 1 and frame_start → no train_hit; hit_count=0; armed=1.
- 5 overlapping pixels, frame_start, burst driven high 3 clocks later → train_hit and shot_clear each high exactly 1 cycle, one clock after frame_start; hit_count=1; state BURSTING.
- After the previous case, train_reset pulses for 16 clocks, then 30 frames pass, each with 10 overlapping pixels → no train_hit during cooldown. The first hit fires after the 31st frame closes; hit_count=2.
- Hit fired, burst held low for 20 clocks → ack_err=1 at clock 16 after FIRE; armed=1; no second pulse until the next qualifying frame.
- Force hit_count to 255 via 255 full hit cycles (shortened parameters), then one more hit → hit_count stays 255; train_hit still pulses.
- Reset asserted while in BURSTING → next cycle armed=1, hit_count=0, train_hit=0, overlap_cnt=0.
